// File: rtl/rr_arbiter8.sv
// ---------------------------------------------------------------------------
// rr_arbiter8 -- round-robin arbiter sharing one downstream resource among
// eight requesters.
//
// A grant is issued one cycle after a request is seen in IDLE. It is held until
// the owner releases it, its request drops, the arbiter is disabled, or the hold
// limit expires. Priority then rotates to the requester after the last owner.
// Exactly one idle cycle always separates two grants. This gives the downstream
// select lines a clean turnaround cycle.
//
// Parameters
//   MAX_HOLD   maximum consecutive grant cycles (0 = unlimited, 0..255)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   en         arbiter enable; low blocks new grants and releases the current one
//   req[7:0]   level-sensitive request vector, bit i = requester i
//   done       release strobe from the current owner (ignored while idle)
//   gnt[7:0]   registered one-hot grant, zero when idle
//   gnt_idx    binary index of the granted requester, zero when idle
//   gnt_valid  high while a grant is active
//   timeout    one-cycle pulse when a grant is force-released by the hold limit
// ---------------------------------------------------------------------------
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // The hold limit is compared against the count of cycles already held.
    // The count starts at 0 on the first grant cycle, so the last permitted
    // cycle is MAX_HOLD-1.
    localparam bit         HOLD_LIMIT_ON = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST     = HOLD_LIMIT_ON ? 8'(MAX_HOLD - 1) : 8'd0;

    state_t      state_q;
    logic [7:0]  gnt_q;
    logic [2:0]  gnt_idx_q;
    logic        gnt_valid_q;
    logic        timeout_q;
    logic [2:0]  ptr_q;
    logic [7:0]  hold_cnt_q;

    logic [7:0]  hold_cnt_d;
    logic [2:0]  ptr_d;

    // Request vector rotated so that position 0 is the current priority
    // pointer. The first set bit of req_rot is the winner's offset from ptr.
    logic [7:0]  req_rot;
    logic        win_found;
    logic [2:0]  win_ofs;
    logic [2:0]  win_idx;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            assign req_rot[gi] = req[ptr_q + 3'(gi)];
        end
    endgenerate

    always_comb begin
        win_found = 1'b0;
        win_ofs   = 3'd0;
        // Scan from the far end so that the lowest offset is the final assignment.
        for (int k = 7; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_found = 1'b1;
                win_ofs   = 3'(k);
            end
        end
    end

    assign win_idx = ptr_q + win_ofs;

    // Release causes while a grant is held
    logic rel_done;
    logic rel_req;
    logic rel_en;
    logic rel_hold;
    logic rel_any;

    assign rel_done = done;
    assign rel_req  = ~req[gnt_idx_q];
    assign rel_en   = ~en;
    assign rel_hold = HOLD_LIMIT_ON && (hold_cnt_q == HOLD_LAST);
    assign rel_any  = rel_done | rel_req | rel_en | rel_hold;

    // Saturating hold counter and the rotated pointer applied on release
    assign hold_cnt_d = (hold_cnt_q == 8'hFF) ? hold_cnt_q : hold_cnt_q + 8'd1;
    assign ptr_d      = gnt_idx_q + 3'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 8'h00;
            gnt_idx_q   <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            ptr_q       <= 3'd0;
            hold_cnt_q  <= 8'd0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (en && win_found) begin
                        state_q     <= ST_GRANT;
                        gnt_q       <= 8'b1 << win_idx;
                        gnt_idx_q   <= win_idx;
                        gnt_valid_q <= 1'b1;
                        hold_cnt_q  <= 8'd0;
                    end
                end
                ST_GRANT: begin
                    if (rel_any) begin
                        state_q     <= ST_IDLE;
                        gnt_q       <= 8'h00;
                        gnt_idx_q   <= 3'd0;
                        gnt_valid_q <= 1'b0;
                        ptr_q       <= ptr_d;
                        // Flag only a release that the hold limit alone forced
                        timeout_q   <= rel_hold & ~(rel_done | rel_req | rel_en);
                    end else begin
                        hold_cnt_q  <= hold_cnt_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one downstream resource among 8 requesters.
- Produces a registered one-hot grant and its 3-bit binary index, plus a valid flag.
- Holds each grant until the owner releases it or a hold-limit timeout fires, then rotates priority.
- Sits in front of shared combinational datapaths. The 3-bit index drives their select lines directly.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one grant may be held. 0 disables the timeout. Legal range 0..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- en  input  1  arbiter enable. Low means no new grants, and any current grant is released.
- req  input  8  request vector, bit i = requester i. Level-sensitive; must stay high while the requester wants or holds the grant.
- done  input  1  release strobe from the current grant owner. Sampled only in GRANT.
- gnt  output  8  registered one-hot grant, all-zero when idle
- gnt_idx  output  3  binary index of the set gnt bit, 0 when gnt_valid=0
- gnt_valid  output  1  high while a grant is active
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD

Behaviour:
- Reset: when rst_n=0 at a clk edge, all of the following take effect on that edge:
  - gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0
  - priority pointer ptr=3'd0, state=IDLE, hold_cnt=0
  - Reset overrides every other input, including in the middle of a grant. There is no release pulse and ptr is not advanced.
- Internal state: ptr[2:0] is the highest-priority requester. hold_cnt is 8 bits.
- IDLE state:
  - If en=1 and req!=0, select the winner w = the first set bit of req scanning ptr, ptr+1, ..., 7, 0, ..., ptr-1 (mod 8).
  - On the next edge: gnt=1<<w, gnt_idx=w, gnt_valid=1, hold_cnt=0, state=GRANT.
  - Latency from req/en sampled high to gnt visible is 1 cycle.
  - Otherwise stay in IDLE with outputs at their zero values.
- GRANT state: a release occurs at the edge where any of the following holds:
  - (a) done=1
  - (b) req[gnt_idx]=0
  - (c) en=0
  - (d) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1
- On release, at the next edge:
  - gnt=0, gnt_idx=0, gnt_valid=0
  - ptr=gnt_idx+1 mod 8 (wrap 7 to 0)
  - state=IDLE
  - timeout=1 for exactly that cycle, only when (d) is the sole cause. If (a), (b) or (c) is also true, timeout stays 0.
- No release: hold_cnt increments and saturates at 255. The grant is unchanged, even if a higher-priority req arrives (no preemption).
- With MAX_HOLD=N>0 and no other release cause, gnt_valid is high for exactly N cycles.
- There is always exactly one IDLE cycle between consecutive grants (bus turnaround). Maximum throughput is therefore one grant per 2 cycles with 1-cycle holds.
- done while in IDLE is ignored.
- Changes to req bits other than req[gnt_idx] during GRANT are ignored.
- gnt is always zero or one-hot, and gnt_idx is always consistent with it.
- Fairness: with all 8 requesters continuously requesting and each holding 1 cycle, grants occur in the order 0,1,...,7,0 (wrap-around).

Test Plan:
- Reset with req=8'hFF, then en=1 for 1 cycle -> gnt=8'h01, gnt_idx=0, gnt_valid=1 one cycle after en is sampled.
- req=8'hFF held, done pulsed on each grant's first cycle -> gnt_idx sequence 0,1,...,7,0, with an idle cycle (gnt=0) between each grant.
- ptr=6 (after serving requester 5), req=8'h21 -> grant to idx 0 (scan 6,7,0), then ptr=1. Next grant with req=8'h21 goes to idx 5.
- MAX_HOLD=4, req=8'h08 held, done=0 -> gnt=8'h08 for exactly 4 cycles, timeout pulses 1 cycle coincident with gnt dropping, next grant idx 3 after one idle cycle.
- During grant to idx 2: (i) drop req[2] -> release next edge, timeout=0. (ii) en=0 -> release next edge. (iii) rst_n=0 -> all outputs 0 next edge, ptr=0.
- done=1 and hold_cnt==MAX_HOLD-1 on the same edge -> release, timeout stays 0. done pulsed in IDLE with req=0 -> no change.
